// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program launch sequencer.
// Holds the FSM state encoding and the program start-address table.
package prog_sequencer_pkg;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    // Entry 0 is launched first; indexed by the 2-bit program index
    localparam logic [3:0][ADDR_W-1:0] PROG_BASE = {
        10'd384, 10'd256, 10'd128, 10'd4
    };

endpackage

// File: rtl/seq_watchdog.sv
// Saturating RUN-cycle counter with the watchdog limit compare.
// Clears when the sequencer heads back towards a new launch.
module seq_watchdog
    import prog_sequencer_pkg::*;
#(
    parameter int MAX_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = run && (count == LIMIT);

endmodule

// File: rtl/prog_sequencer.sv
// Launch/run/done sequencer rotating through a fixed set of programs.
// Gates PC control from the decoder and enforces a RUN watchdog.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int NUM_PROGS  = 3,
    parameter int MAX_CYCLES = 1023
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              Jump,
    input  logic              BOE,
    input  logic              IsEqual,
    output logic              PcInit,
    output logic [ADDR_W-1:0] PcBase,
    output logic              PcHold,
    output logic              PcJump,
    output logic              PcBoe,
    output logic [1:0]        ProgIdx,
    output logic [CNT_W-1:0]  CycleCount,
    output logic              Done,
    output logic              Timeout
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

    logic [1:0] rst_sync;
    logic       rst_n;
    state_t     state;
    state_t     next;
    logic       expire;
    logic       wd_clear;
    logic       timeout_q;
    logic [1:0] idx;

    // Assert asynchronously, release on a clock edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   if (Start) next = S_ARMED;
            S_ARMED:  if (!Start) next = S_LAUNCH;
            S_LAUNCH: next = S_RUN;
            S_RUN:    if (Halt || expire) next = S_DONE;
            S_DONE:   if (Start) next = S_ARMED;
            default:  next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
            end
            // Halt on the limit cycle ends the program normally
            if (state == S_RUN && next == S_DONE) begin
                timeout_q <= expire && !Halt;
            end else if (next != S_DONE) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign wd_clear = (next != S_RUN) && (next != S_DONE);

    seq_watchdog #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_watchdog (
        .clk   (Clk),
        .rst_n (rst_n),
        .clear (wd_clear),
        .run   (state == S_RUN),
        .count (CycleCount),
        .expire(expire)
    );

    always_comb begin
        PcInit = 1'b0;
        PcHold = 1'b1;
        PcJump = 1'b0;
        PcBoe  = 1'b0;
        Done   = 1'b0;
        unique case (state)
            S_LAUNCH: PcInit = 1'b1;
            S_RUN: begin
                PcHold = 1'b0;
                PcJump = Jump && !Halt;
                PcBoe  = BOE && IsEqual && !Halt;
            end
            S_DONE:   Done = 1'b1;
            default:  ;
        endcase
    end

    assign PcBase  = PROG_BASE[idx];
    assign ProgIdx = idx;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a short watchdog limit.
// Walks reset, launches, PC gating, halt, timeout and mid-run reset.
module tb_prog_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Halt = 1'b0;
    logic        Jump = 1'b0;
    logic        BOE = 1'b0;
    logic        IsEqual = 1'b0;
    logic        PcInit;
    logic [9:0]  PcBase;
    logic        PcHold;
    logic        PcJump;
    logic        PcBoe;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCount;
    logic        Done;
    logic        Timeout;

    int n_checks = 0;
    int n_pass   = 0;

    prog_sequencer #(
        .NUM_PROGS (3),
        .MAX_CYCLES(8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .Jump      (Jump),
        .BOE       (BOE),
        .IsEqual   (IsEqual),
        .PcInit    (PcInit),
        .PcBase    (PcBase),
        .PcHold    (PcHold),
        .PcJump    (PcJump),
        .PcBoe     (PcBoe),
        .ProgIdx   (ProgIdx),
        .CycleCount(CycleCount),
        .Done      (Done),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // From IDLE or DONE: arm, launch, enter RUN
    task automatic launch(input logic [9:0] base, input logic [1:0] idx);
        Start = 1'b1;
        step();
        check("armed_noinit", 32'(PcInit), 32'd0);
        check("armed_done", 32'(Done), 32'd0);
        check("armed_cnt", 32'(CycleCount), 32'd0);
        check("armed_tmo", 32'(Timeout), 32'd0);
        Start = 1'b0;
        step();
        check("launch_init", 32'(PcInit), 32'd1);
        check("launch_base", 32'(PcBase), 32'(base));
        check("launch_hold", 32'(PcHold), 32'd1);
        step();
        check("run_hold", 32'(PcHold), 32'd0);
        check("run_idx", 32'(ProgIdx), 32'(idx));
        check("run_cnt0", 32'(CycleCount), 32'd0);
    endtask

    initial begin
        #1 Reset = 1'b0;
        #1;
        check("rst_hold", 32'(PcHold), 32'd1);
        check("rst_base", 32'(PcBase), 32'd4);
        check("rst_idx", 32'(ProgIdx), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_init", 32'(PcInit), 32'd0);
        check("rst_cnt", 32'(CycleCount), 32'd0);
        step();
        step();
        Reset = 1'b1;
        repeat (4) step();
        check("idle_hold", 32'(PcHold), 32'd1);
        check("idle_idx", 32'(ProgIdx), 32'd0);
        check("idle_done", 32'(Done), 32'd0);
        check("idle_init", 32'(PcInit), 32'd0);

        launch(10'd4, 2'd1);
        Jump = 1'b1;
        #1 check("pc_jump", 32'(PcJump), 32'd1);
        Jump = 1'b0;
        BOE = 1'b1;
        #1 check("boe_neq", 32'(PcBoe), 32'd0);
        IsEqual = 1'b1;
        #1 check("boe_eq", 32'(PcBoe), 32'd1);
        check("boe_nojump", 32'(PcJump), 32'd0);
        BOE = 1'b0;
        IsEqual = 1'b0;
        repeat (5) step();
        check("cnt5", 32'(CycleCount), 32'd5);
        Halt = 1'b1;
        Jump = 1'b1;
        #1 check("halt_jump", 32'(PcJump), 32'd0);
        step();
        Halt = 1'b0;
        check("halt_done", 32'(Done), 32'd1);
        check("halt_tmo", 32'(Timeout), 32'd0);
        check("halt_cnt", 32'(CycleCount), 32'd6);
        #1 check("done_jump", 32'(PcJump), 32'd0);
        Jump = 1'b0;
        step();
        check("done_hold_cnt", 32'(CycleCount), 32'd6);
        check("done_pchold", 32'(PcHold), 32'd1);

        launch(10'd128, 2'd2);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("run_ign_start", 32'(PcHold), 32'd0);
        repeat (6) step();
        check("pre_wd_done", 32'(Done), 32'd0);
        check("pre_wd_cnt", 32'(CycleCount), 32'd7);
        step();
        check("wd_done", 32'(Done), 32'd1);
        check("wd_tmo", 32'(Timeout), 32'd1);
        check("wd_cnt", 32'(CycleCount), 32'd8);

        launch(10'd256, 2'd0);
        repeat (7) step();
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        check("lim_halt_done", 32'(Done), 32'd1);
        check("lim_halt_tmo", 32'(Timeout), 32'd0);

        launch(10'd4, 2'd1);
        step();
        step();
        Reset = 1'b0;
        #1;
        check("mid_rst_hold", 32'(PcHold), 32'd1);
        check("mid_rst_idx", 32'(ProgIdx), 32'd0);
        check("mid_rst_cnt", 32'(CycleCount), 32'd0);
        check("mid_rst_done", 32'(Done), 32'd0);
        Reset = 1'b1;
        repeat (4) step();
        check("post_rst_done", 32'(Done), 32'd0);
        check("post_rst_hold", 32'(PcHold), 32'd1);
        check("post_rst_init", 32'(PcInit), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3, number of programs in the launch rotation.
REQ-002 Parameter MAX_CYCLES, default 1023, RUN-cycle watchdog limit.
REQ-003 Port Clk  input  1  single clock; all state updates on posedge.
REQ-004 Port Reset  input  1  asynchronous, active-low reset.
REQ-005 Port Start  input  1  launch request from the host, level-sampled.
REQ-006 Port Halt  input  1  decoded halt instruction from the instruction decoder.
REQ-007 Port Jump  input  1  decoded absolute-jump request.
REQ-008 Port BOE  input  1  decoded branch-on-equal request.
REQ-009 Port IsEqual  input  1  ALU equal flag.
REQ-010 Port PcInit  output  1  one-cycle pulse: program counter loads PcBase.
REQ-011 Port PcBase  output  10  start address of the program being launched.
REQ-012 Port PcHold  output  1  program counter holds its value when high.
REQ-013 Port PcJump  output  1  gated absolute jump to the program counter.
REQ-014 Port PcBoe  output  1  gated PC-relative branch to the program counter.
REQ-015 Port ProgIdx  output  2  index of the current or most recent program.
REQ-016 Port CycleCount  output  16  RUN cycles of the current program.
REQ-017 Port Done  output  1  high from program end until the next launch.
REQ-018 Port Timeout  output  1  high with Done when the watchdog caused the end.

Function
REQ-019 The FSM SHALL have states IDLE, ARMED, LAUNCH, RUN and DONE.
REQ-020 IDLE: Start=1 -> ARMED; otherwise stay.
REQ-021 ARMED: stay while Start=1; Start=0 -> LAUNCH. The posedge that first samples Start=1 SHALL NOT launch.
REQ-022 LAUNCH lasts exactly one cycle: PcInit=1 and PcBase=PROG_BASE[ProgIdx]; then -> RUN.
REQ-023 PcHold SHALL be 1 in IDLE, ARMED, LAUNCH and DONE, and 0 in RUN.
REQ-024 RUN: PcJump=Jump and PcBoe=BOE&IsEqual, combinationally; both SHALL be 0 in every other state.
REQ-025 RUN: Halt=1 -> DONE; that cycle PcJump=PcBoe=0 (Halt wins over simultaneous Jump or BOE).
REQ-026 RUN: CycleCount increments by 1 per cycle, starting from 0 on entry to RUN.
REQ-027 RUN: CycleCount==MAX_CYCLES-1 without Halt -> DONE with Timeout=1. Halt in that same cycle SHALL give Timeout=0.
REQ-028 CycleCount SHALL saturate at 16'hFFFF and hold its value in DONE.
REQ-029 DONE: Done=1; Start=1 -> ARMED, which clears Done, Timeout and CycleCount.
REQ-030 ProgIdx SHALL increment on the LAUNCH->RUN transition and wrap from NUM_PROGS-1 to 0.
REQ-031 Start asserted in LAUNCH or RUN SHALL be ignored.
REQ-032 Halt, Jump, BOE and IsEqual SHALL be ignored outside RUN.

Reset
REQ-033 Reset=0 SHALL asynchronously force IDLE, ProgIdx=0, CycleCount=0, Done=0, Timeout=0 and PcInit=PcJump=PcBoe=0.
REQ-034 In reset, PcHold SHALL be 1 and PcBase=PROG_BASE[0].
REQ-035 Reset asserted mid-RUN SHALL abandon the program; no Done pulse SHALL result.
REQ-036 Reset deassertion SHALL be synchronised to Clk.

Structure
REQ-037 A shared package SHALL hold the state enum, PROG_BASE (4, 128, 256, 384) and the 10-bit address width.
REQ-038 One sub-module, seq_watchdog, SHALL hold the saturating CycleCount and the timeout compare.

Verification
REQ-039 Reset=0 then release, Start held 0 -> PcHold=1, ProgIdx=0, Done=0, no PcInit.
REQ-040 Start high for one edge then low -> PcInit=1 with PcBase=4 in LAUNCH, RUN on the next edge, ProgIdx=1.
REQ-041 RUN with Jump=1; then BOE=1, IsEqual=0; then BOE=1, IsEqual=1 -> PcJump=1; PcBoe=0; PcBoe=1.
REQ-042 Halt and Jump together at CycleCount=5 -> PcJump=0, DONE, Done=1, Timeout=0, CycleCount holds 6.
REQ-043 MAX_CYCLES=8, no Halt -> DONE after 8 RUN cycles with Timeout=1.
REQ-044 Three launches, then a fourth -> PcBase 4, 128, 256, then 4 again; Reset mid-RUN -> IDLE with no Done.
